// File: rtl/tick_sched_pkg.sv
// rtl/tick_sched_pkg.sv - shared types and default widths for the tick scheduler
package tick_sched_pkg;

  localparam int DIV_W         = 32;
  localparam int DEFAULT_TAP_W = 5;
  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic [1:0] {CH_IDLE, CH_ARM, CH_RUN} ch_state_t;

endpackage

// File: rtl/tick_channel.sv
// rtl/tick_channel.sv - one requester: tap latch, edge detect, down-counter and IDLE/ARM/RUN FSM
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int TAP_W = DEFAULT_TAP_W,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DIV_W-1:0] s,
  input  logic             accept,
  input  logic             stop,
  input  logic [TAP_W-1:0] cfg_tap,
  input  logic [CNT_W-1:0] cfg_count,
  output logic             tick,
  output logic             done,
  output logic             busy
);

  ch_state_t        state, state_nx;
  logic [TAP_W-1:0] tap;
  logic [CNT_W-1:0] remaining;
  logic             prev;
  logic             tap_bit;
  logic             rise;
  logic             fire;
  logic             last;

  assign tap_bit = s[tap];
  assign rise    = tap_bit & ~prev;
  // Any accept to this channel masks the tick it would otherwise launch this cycle.
  assign fire    = rise & (state == CH_RUN) & ~accept;
  // remaining == 0 while running means a continuous program.
  assign last    = (remaining == CNT_W'(1));
  assign busy    = (state != CH_IDLE);

  always_comb begin
    state_nx = state;
    if (accept) begin
      state_nx = stop ? CH_IDLE : CH_ARM;
    end else begin
      case (state)
        CH_ARM:  state_nx = CH_RUN;
        CH_RUN:  if (fire && last) state_nx = CH_IDLE;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= CH_IDLE;
      tap       <= '0;
      remaining <= '0;
      prev      <= 1'b0;
      tick      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nx;
      // Tracking the tap every cycle means ARM reloads prev from the new tap.
      prev  <= tap_bit;
      tick  <= fire;
      done  <= fire & last;
      if (accept && !stop) begin
        tap       <= cfg_tap;
        remaining <= cfg_count;
      end else if (fire && remaining != '0) begin
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - shares divided_clocks taps between N_CH tick-enable requesters
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int  N_CH  = 4,
  parameter int  TAP_W = DEFAULT_TAP_W,
  parameter int  CNT_W = DEFAULT_CNT_W,
  localparam int CH_W  = $clog2(N_CH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DIV_W-1:0] divided_clocks,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [TAP_W-1:0] cfg_tap,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             cfg_stop,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  done,
  output logic [N_CH-1:0]  busy,
  output logic             cfg_err
);

  logic [DIV_W-1:0] s;
  logic             accept;

  assign accept = cfg_valid & cfg_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s         <= '0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      s         <= divided_clocks;
      cfg_ready <= 1'b1;
      cfg_err   <= accept & (cfg_ch >= CH_W'(N_CH));
    end
  end

  // An out-of-range cfg_ch matches no channel, so nothing but cfg_err reacts.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    tick_channel #(
      .TAP_W (TAP_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .s         (s),
      .accept    (accept && (cfg_ch == CH_W'(i))),
      .stop      (cfg_stop),
      .cfg_tap   (cfg_tap),
      .cfg_count (cfg_count),
      .tick      (tick[i]),
      .done      (done[i]),
      .busy      (busy[i])
    );
  end

endmodule
